// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one shared single-ported memory
// One transaction in flight; data port wins unless fetch has been starved STARVE_LIMIT times.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              proto_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e            state_q, state_d;
  logic              gnt_data_q, gnt_data_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        starve_q, starve_d;
  logic              perr_q, perr_d;
  logic              force_fetch;
  logic              resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      gnt_data_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      starve_q   <= 4'd0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      gnt_data_q <= gnt_data_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      starve_q   <= starve_d;
      perr_q     <= perr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_data_d  = gnt_data_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    starve_d    = starve_q;
    perr_d      = perr_q;
    force_fetch = if_req && (starve_q == LIMIT);
    resp        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (d_req && !force_fetch) begin
          state_d    = S_REQ;
          gnt_data_d = 1'b1;
          we_d       = d_we;
          addr_d     = d_addr;
          wdata_d    = d_wdata;
          if (!if_req)
            starve_d = 4'd0;
          else if (starve_q != LIMIT)
            starve_d = starve_q + 4'd1;
        end else if (if_req) begin
          state_d    = S_REQ;
          gnt_data_d = 1'b0;
          we_d       = 1'b0;
          addr_d     = if_addr;
          starve_d   = 4'd0;
        end
      end
      S_REQ: begin
        if (mem_ready)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          resp    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A response with no transaction waiting for it is a memory-side protocol violation.
    if (mem_rvalid && (state_q != S_WAIT))
      perr_d = 1'b1;
  end

  assign mem_req   = (state_q == S_REQ);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign proto_err = perr_q;

  assign if_ack   = resp && !gnt_data_q;
  assign d_ack    = resp && gnt_data_q;
  assign if_rdata = if_ack ? mem_rdata : '0;
  assign d_rdata  = d_ack ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata;
  logic        if_ack, d_ack;
  logic [31:0] if_rdata, d_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic exp_data [6];

  initial begin
    exp_data = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    step(); #1;
    chk("rst_busy", busy, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    step(); rst = 1'b0;

    // single fetch, zero-wait memory
    step(); if_req = 1'b1; if_addr = 32'h0000_0010; #1;
    chk("f_c0_mem_req", mem_req, 0);
    step(); mem_ready = 1'b1; #1;
    chk("f_c1_mem_req", mem_req, 1);
    chk("f_c1_mem_addr", mem_addr, 32'h10);
    chk("f_c1_mem_we", mem_we, 0);
    chk("f_c1_if_ack", if_ack, 0);
    step(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0050_0093; #1;
    chk("f_c2_if_ack", if_ack, 1);
    chk("f_c2_if_rdata", if_rdata, 32'h0050_0093);
    chk("f_c2_d_ack", d_ack, 0);
    chk("f_c2_mem_req", mem_req, 0);
    step(); if_req = 1'b0; mem_rvalid = 1'b0; #1;
    chk("f_c3_if_ack", if_ack, 0);
    chk("f_c3_if_rdata", if_rdata, 0);
    chk("f_c3_busy", busy, 0);

    // store with memory back-pressure
    step(); d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFE_BABE; #1;
    for (int i = 0; i < 3; i++) begin
      step(); mem_ready = 1'b0; #1;
      chk("st_req_mem_req", mem_req, 1);
      chk("st_req_mem_addr", mem_addr, 32'h100);
      chk("st_req_mem_wdata", mem_wdata, 32'hCAFE_BABE);
      chk("st_req_mem_we", mem_we, 1);
    end
    step(); mem_ready = 1'b1; #1;
    chk("st_accept_mem_req", mem_req, 1);
    step(); mem_ready = 1'b0; #1;
    chk("st_wait_d_ack", d_ack, 0);
    chk("st_wait_mem_req", mem_req, 0);
    chk("st_wait_busy", busy, 1);
    step(); mem_rvalid = 1'b1; mem_rdata = 32'h0; #1;
    chk("st_resp_d_ack", d_ack, 1);
    chk("st_resp_if_ack", if_ack, 0);
    step(); d_req = 1'b0; d_we = 1'b0; mem_rvalid = 1'b0; #1;
    chk("st_after_d_ack", d_ack, 0);
    chk("st_after_busy", busy, 0);

    // simultaneous requests: data first, then fetch after an IDLE cycle
    step(); if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_addr = 32'h200; #1;
    step(); mem_ready = 1'b1; #1;
    chk("col_d_mem_addr", mem_addr, 32'h200);
    chk("col_d_mem_we", mem_we, 0);
    step(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_0001; #1;
    chk("col_d_ack", d_ack, 1);
    chk("col_d_rdata", d_rdata, 32'hDEAD_0001);
    chk("col_d_if_ack", if_ack, 0);
    step(); d_req = 1'b0; mem_rvalid = 1'b0; #1;
    chk("col_idle_mem_req", mem_req, 0);
    chk("col_idle_busy", busy, 0);
    step(); mem_ready = 1'b1; #1;
    chk("col_f_mem_req", mem_req, 1);
    chk("col_f_mem_addr", mem_addr, 32'h20);
    step(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBEEF_0002; #1;
    chk("col_f_if_ack", if_ack, 1);
    chk("col_f_if_rdata", if_rdata, 32'hBEEF_0002);
    step(); if_req = 1'b0; mem_rvalid = 1'b0; #1;

    // starvation: four data grants, one forced fetch, then data again
    step(); if_req = 1'b1; if_addr = 32'h40; d_req = 1'b1; d_addr = 32'h400; #1;
    for (int t = 0; t < 6; t++) begin
      chk("stv_idle_busy", busy, 0);
      step(); mem_ready = 1'b1; #1;
      chk($sformatf("stv_addr_%0d", t), mem_addr, exp_data[t] ? 32'h400 : 32'h40);
      step(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'(t); #1;
      chk($sformatf("stv_d_ack_%0d", t), d_ack, exp_data[t] ? 1 : 0);
      chk($sformatf("stv_if_ack_%0d", t), if_ack, exp_data[t] ? 0 : 1);
      step(); mem_rvalid = 1'b0;
      if (t == 4) if_req = 1'b0;
      if (t == 5) d_req = 1'b0;
      #1;
    end
    chk("stv_end_busy", busy, 0);

    // spurious response during REQ
    step(); d_req = 1'b1; d_addr = 32'h300; #1;
    chk("sp_pre_proto_err", proto_err, 0);
    step(); mem_rvalid = 1'b1; mem_ready = 1'b0; #1;
    chk("sp_mem_req", mem_req, 1);
    chk("sp_d_ack", d_ack, 0);
    chk("sp_if_ack", if_ack, 0);
    chk("sp_d_rdata", d_rdata, 0);
    step(); mem_rvalid = 1'b0; mem_ready = 1'b1; #1;
    chk("sp_proto_err_set", proto_err, 1);
    step(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234; #1;
    chk("sp_real_d_ack", d_ack, 1);
    chk("sp_real_d_rdata", d_rdata, 32'h1234);
    step(); mem_rvalid = 1'b0; d_req = 1'b0; #1;
    chk("sp_proto_err_sticky", proto_err, 1);
    chk("sp_busy", busy, 0);

    // asynchronous reset in WAIT with a read pending
    step(); d_req = 1'b1; d_addr = 32'h500; #1;
    step(); mem_ready = 1'b1; #1;
    step(); mem_ready = 1'b0; #1;
    chk("ar_wait_busy", busy, 1);
    #1; rst = 1'b1; #1;
    chk("ar_busy", busy, 0);
    chk("ar_mem_req", mem_req, 0);
    chk("ar_mem_addr", mem_addr, 0);
    chk("ar_proto_err", proto_err, 0);
    step(); rst = 1'b0; d_req = 1'b0; #1;
    chk("ar_after_busy", busy, 0);
    step(); mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA; #1;
    chk("ar_late_d_ack", d_ack, 0);
    chk("ar_late_d_rdata", d_rdata, 0);
    step(); mem_rvalid = 1'b0; #1;
    chk("ar_late_proto_err", proto_err, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the instruction-fetch port (IF stage) and the data port (MEM stage) of the 5-stage pipeline.
- Runs a request/response FSM with one transaction outstanding at a time.
- Data port has fixed priority; a starvation counter guarantees forward progress for fetch.
- The pipeline's hazard logic derives stalls from port `req & ~ack`.

Parameters:
- ADDR_W, 32, address width for both ports and the memory.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive data grants, with if_req pending, after which fetch is forced; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req.
- if_ack  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  DATA_W  fetch data; valid only when if_ack, else 0.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ack  out  1  one-cycle completion pulse for data.
- d_rdata  out  DATA_W  load data; valid only when d_ack, else 0.
- mem_req  out  1  request to memory.
- mem_we  out  1  write enable to memory.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_ready  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  memory response (reads and writes).
- mem_rdata  in  DATA_W  memory read data, valid with mem_rvalid.
- busy  out  1  FSM not in IDLE.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset, asynchronous, from any state:
  - State = IDLE; starve_cnt = 0.
  - mem_req, mem_we, mem_addr, mem_wdata, proto_err = 0.
  - Acks and rdata outputs read 0.
  - An mem_rvalid arriving after reset is treated as spurious (see proto_err).
- States: IDLE, REQ, WAIT.
- IDLE (arbitration):
  - If d_req && !(if_req && starve_cnt == STARVE_LIMIT): grant data.
  - Else if if_req: grant fetch.
  - Else: stay in IDLE.
  - On grant, at the clock edge:
    - Register the granted port's addr; also we/wdata for data, we = 0 for fetch.
    - Record the granted port in gnt_sel; go to REQ.
- REQ:
  - mem_req = 1; mem_we/addr/wdata held stable from the registers.
  - On mem_ready = 1, go to WAIT at the edge; otherwise stay in REQ.
  - No abort: a requester dropping req in REQ or WAIT is a requester bug. The transaction completes and the ack still pulses.
- WAIT:
  - mem_req = 0.
  - When mem_rvalid = 1, in the same cycle and combinationally:
    - Pulse the ack of the gnt_sel port.
    - Drive that port's rdata = mem_rdata.
  - Next state is IDLE.
  - Requesters update req at that same edge, so IDLE sees fresh requests.
- Latency with zero-wait memory (mem_ready = 1 in REQ, mem_rvalid = 1 in the first WAIT cycle):
  - req rises in cycle 0, ack in cycle 2 (3 cycles).
  - Back-to-back throughput: one transaction per 3 cycles.
- Starvation counter (updated at the IDLE grant edge):
  - Data grant while if_req = 1: starve_cnt += 1, saturating at STARVE_LIMIT.
  - Fetch grant, or data grant with if_req = 0: starve_cnt = 0.
- Simultaneous requests: d_req = if_req = 1 with starve_cnt < STARVE_LIMIT grants data.
- proto_err: set when mem_rvalid = 1 in IDLE or REQ; cleared only by rst. Such an rvalid produces no ack.
- mem_ready outside REQ is ignored.
- Width rules: all data and address paths are pass-through; no arithmetic apart from the 4-bit saturating starve_cnt.

Test Plan:
- Reset: assert rst mid-WAIT with a data read pending -> busy = 0, mem_req = 0 immediately (async); a later mem_rvalid sets proto_err = 1 and produces no ack.
- Single fetch: if_addr = 0x0000_0010, zero-wait memory returning 0x0050_0093 -> mem_req in cycle 1 with mem_addr = 0x10, mem_we = 0; if_ack = 1 and if_rdata = 0x0050_0093 in cycle 2 only.
- Store with waits: d_we = 1, d_addr = 0x100, d_wdata = 0xCAFE_BABE, mem_ready low for 3 cycles, rvalid 2 cycles later:
  - mem_addr/mem_wdata stay stable throughout REQ.
  - d_ack is a single pulse; if_ack stays 0.
- Collision: if_req and d_req rise together -> data granted first; fetch mem_req follows after d_ack, with the next IDLE cycle in between.
- Starvation: d_req held high continuously with if_req high, STARVE_LIMIT = 4 -> exactly 4 data grants, then 1 fetch grant, then data again.
- Spurious response: mem_rvalid = 1 while in REQ -> no ack, proto_err = 1 and stays 1 until rst.
